// File: rtl/ncdc_display_pkg.sv
// Shared types and segment constants for the multiplexed BCD seven-segment display.
package ncdc_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEG_W      = 7;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  // Entry [n] is the pattern for decimal digit n
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low segment decode, with blank override and dash for 10..15.
module bcd_to_7seg
  import ncdc_display_pkg::*;
(
  input  bcd_digit_t       digit_i,
  input  logic             blank_i,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    if (blank_i) begin
      seg_c = SEG_BLANK;
    end else if (digit_i <= DIGIT_W'(9)) begin
      seg_c = SEG_TABLE[digit_i];
    end
  end

endmodule

// File: rtl/bcd_sevenseg_scanner.sv
// Four-digit time-multiplexed seven-segment driver: shadow-latched BCD input,
// refresh tick, optional leading-zero blanking, registered anode/segment outputs.
module bcd_sevenseg_scanner
  import ncdc_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]   bcd_in,
  input  logic                            load,
  input  logic                            lz_blank,
  output logic [NUM_DIGITS-1:0]           an,
  output logic [SEG_W-1:0]                seg
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  bcd_digit_t [NUM_DIGITS-1:0]       shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]             an_q, an_d;
  logic [SEG_W-1:0]                  seg_q, seg_d;

  logic       tick_c;
  logic       blank_c;
  bcd_digit_t sel_digit_c;
  logic [SEG_W-1:0] dec_seg_c;

  // Refresh divider, digit index and shadow capture
  always_comb begin
    tick_c   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d    = tick_c ? '0 : cnt_q + CNT_W'(1);
    idx_d    = tick_c ? idx_q + IDX_W'(1) : idx_q;
    shadow_d = load ? bcd_in : shadow_q;
  end

  // A digit blanks only if it and every more-significant digit are zero; digit0 never blanks
  always_comb begin
    sel_digit_c = shadow_q[idx_q];
    blank_c     = lz_blank && (idx_q != '0);
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if ((k >= 32'(idx_q)) && (shadow_q[k] != '0)) begin
        blank_c = 1'b0;
      end
    end
  end

  bcd_to_7seg u_dec (
    .digit_i (sel_digit_c),
    .blank_i (blank_c),
    .seg_c   (dec_seg_c)
  );

  always_comb begin
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = dec_seg_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      an_q     <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_bcd_sevenseg_scanner.sv
// Scoreboard bench for bcd_sevenseg_scanner with REFRESH_DIV=4: a behavioural model
// queues the expected an/seg for each edge and the result is checked just after it.
module tb_bcd_sevenseg_scanner;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;

  bcd_sevenseg_scanner #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .load     (load),
    .lz_blank (lz_blank),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  // Model state
  int          m_cnt = 0;
  int          m_idx = 0;
  logic [15:0] m_sh  = '0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%b want=%b (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input logic [15:0] sh, input int idx, input logic lz);
    logic [15:0] upper;
    logic [3:0]  d;
    upper = sh >> (4 * idx);
    d     = upper[3:0];
    if (lz && idx != 0 && upper == 16'h0) return 7'b1111111;
    if (d > 4'd9) return 7'b0111111;
    return seg_ref[d];
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] b, input logic lz);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst = r; load = l; bcd_in = b; lz_blank = lz;
    if (r) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
    end else begin
      e.an  = 4'b1111;
      e.an[m_idx] = 1'b0;
      e.seg = model_seg(m_sh, m_idx, lz);
    end
    exp_q.push_back(e);
    if (r) begin
      m_cnt = 0; m_idx = 0; m_sh = '0;
    end else begin
      if (l) m_sh = b;
      if (m_cnt == DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("an", 16'(an), 16'(got.an));
    check("seg", 16'(seg), 16'(got.seg));
  endtask

  task automatic idle(input int n, input logic lz);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, bcd_in, lz);
  endtask

  initial begin
    step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h9999, 1'b0);
    idle(20, 1'b0);

    step(1'b0, 1'b1, 16'h1234, 1'b0);
    idle(16, 1'b0);

    step(1'b0, 1'b1, 16'h0070, 1'b1);
    idle(16, 1'b1);
    idle(16, 1'b0);

    step(1'b0, 1'b1, 16'h00A0, 1'b0);
    idle(16, 1'b0);
    idle(16, 1'b1);

    // Input changes without load must not reach the display
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h5678 + 16'(i), 1'b0);

    // Load coincident with a tick
    for (int i = 0; i < 8 && m_cnt != DIV - 1; i++) step(1'b0, 1'b0, bcd_in, 1'b0);
    check("tick_align", 16'(m_cnt), 16'(DIV - 1));
    step(1'b0, 1'b1, 16'h8642, 1'b0);
    idle(8, 1'b0);

    // Reset mid-scan at digit 2
    for (int i = 0; i < 32 && m_idx != 2; i++) step(1'b0, 1'b0, bcd_in, 1'b0);
    check("idx_align", 16'(m_idx), 16'd2);
    step(1'b0, 1'b0, bcd_in, 1'b0);
    step(1'b1, 1'b1, 16'h4321, 1'b0);
    idle(20, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      logic [15:0] b;
      b = 16'($urandom);
      if ($urandom_range(0, 1) == 0) b[15:8] = 8'h00;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0), b,
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_sevenseg_scanner.md
BCD_SEVENSEG_SCANNER -- requirements
Module: bcd_sevenseg_scanner

Interface
REQ-001 Parameter: REFRESH_DIV, 100000, clock cycles each digit stays displayed (legal range 2 or more).
REQ-002 Port: clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: bcd_in  input  16  four BCD digits from the ripple counters; [3:0] is digit0 (least significant) through [15:12] digit3.
REQ-005 Port: load  input  1  when high, bcd_in is captured into the shadow register at that edge.
REQ-006 Port: lz_blank  input  1  enables leading-zero blanking.
REQ-007 Port: an  output  4  digit anodes, active-low, one-hot-low when active.
REQ-008 Port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-009 Shadow register SHALL hold 4 digits and update only on load=1; display SHALL always use the shadow, never bcd_in directly.
REQ-010 Tick counter SHALL count 0..REFRESH_DIV-1 and wrap; tick is asserted in the cycle the count equals REFRESH_DIV-1.
REQ-011 Digit index SHALL advance 0->1->2->3->0 on each tick; wrap 3->0 SHALL be seamless.
REQ-012 an and seg SHALL be registered; they reflect the index and shadow of the previous cycle (1-cycle latency).
REQ-013 an SHALL drive low only bit [index]; all other bits high.
REQ-014 Decode SHALL use these active-low values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Digit values 10..15 SHALL display dash (0111111).
REQ-016 With lz_blank=1, digit k (k=3,2,1) SHALL display blank (1111111) when it and every higher digit equal 0; digit0 SHALL never be blanked.
REQ-017 An invalid digit (10..15) counts as non-zero for blanking.
REQ-018 When a blank is displayed, the anode SHALL still scan normally.
REQ-019 When load and tick occur in the same cycle, both SHALL take effect; the new shadow is displayed from the next registered output.
REQ-020 Changing lz_blank SHALL take effect on the next registered output, with no effect on scan timing.

Reset
REQ-021 rst=1 at a posedge SHALL set tick counter=0, index=0, shadow=0, an=1111, seg=1111111.
REQ-022 rst SHALL override load and tick in the same cycle.
REQ-023 After reset release, the first edge SHALL drive an=1110 showing digit0 (0 -> seg=1000000).
REQ-024 Reset asserted mid-scan SHALL restart scanning at digit0 with a full REFRESH_DIV period.

Structure
REQ-025 Shared package ncdc_display_pkg SHALL hold the bcd_digit_t (4-bit) typedef, NUM_DIGITS=4, the SEG_BLANK and SEG_DASH constants, and the 0..9 segment table.
REQ-026 Sub-module bcd_to_7seg (combinational, 4-bit digit plus blank flag in, 7-bit seg out) SHALL be instantiated once, on the selected digit.
REQ-027 No asynchronous logic; no gated or derived clocks; the tick is an enable only.

Verification (REFRESH_DIV=4)
REQ-028 rst for 2 cycles, then release -> an=1110 and seg=1000000 at the first edge; an steps 1101, 1011, 0111, 1110 every 4 cycles.
REQ-029 load with bcd_in=16'h1234, lz_blank=0 -> scan shows seg 0011001, 0110000, 0100100, 1111001 for digits 0..3.
REQ-030 load 16'h0070, lz_blank=1 -> digit3 and digit2 blank, digit1=1111000, digit0=1000000; with lz_blank=0, digit3 and digit2 show 1000000.
REQ-031 load 16'h00A0 -> digit1 shows dash 0111111 and digit0=1000000; with lz_blank=1, digit3 and digit2 blank.
REQ-032 bcd_in changes without load -> seg unchanged; load coincident with a tick -> the next digit shows the new shadow value.
REQ-033 rst asserted while index=2 -> next edge an=1111, seg=1111111; after release, scan restarts at digit0.
